// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared state encoding and retry counter helpers for the PLL reset sequencer
package pll_rst_pkg;

    localparam int RETRY_W = 8;

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    typedef enum logic [2:0] {
        PLL_RST   = ST_PLL_RST,
        WAIT_LOCK = ST_WAIT_LOCK,
        STABLE    = ST_STABLE,
        RELEASE   = ST_RELEASE,
        RUN       = ST_RUN
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Retry counter sticks at all-ones so a flapping PLL never looks healthy again.
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset, lock qualification and staggered domain reset release
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 20000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_DOMAINS    = 3,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                   clk_in1,
    input  logic                   reset,
    input  logic                   locked,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   ready,
    output logic [RETRY_W-1:0]     retry_count,
    output logic                   lock_lost
);

    localparam int REL_TOTAL = STAGGER_CYCLES * (NUM_DOMAINS + 1);
    localparam int CNT_MAX   = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, REL_TOTAL);
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(PLL_RST_CYCLES);
    localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] REL_LOAD    = CNT_W'(REL_TOTAL);

    state_e                   state;
    logic [CNT_W-1:0]         cnt;
    logic                     lock_s;
    logic [CNT_W-1:0]         rel_elapsed;
    logic [31:0]              rel_elapsed32;
    logic [NUM_DOMAINS-1:0]   rel_hold;
    logic                     cnt_done;

    sync_2ff u_lock_sync (
        .clk   (clk_in1),
        .reset (reset),
        .d     (locked),
        .q     (lock_s)
    );

    assign cnt_done = (cnt <= CNT_W'(1));

    // Cycles since RELEASE entry as of the coming edge; domain i stays held
    // until that reaches its own stagger slot.
    always_comb begin
        rel_elapsed   = REL_LOAD - cnt + CNT_W'(1);
        rel_elapsed32 = 32'(rel_elapsed);
        rel_hold      = '1;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            rel_hold[i] = (rel_elapsed32 < 32'(STAGGER_CYCLES * (i + 1)));
        end
    end

    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state        <= PLL_RST;
            cnt          <= RST_LOAD;
            pll_reset    <= 1'b1;
            domain_reset <= '1;
            ready        <= 1'b0;
            lock_lost    <= 1'b0;
            retry_count  <= '0;
        end else begin
            lock_lost <= 1'b0;
            case (state)
                PLL_RST: begin
                    pll_reset    <= 1'b1;
                    domain_reset <= '1;
                    ready        <= 1'b0;
                    if (cnt_done) begin
                        state     <= WAIT_LOCK;
                        cnt       <= TO_LOAD;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                // Lock is checked before the timeout so a coincident lock wins.
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= STABLE_LOAD;
                    end else if (cnt_done) begin
                        state       <= PLL_RST;
                        cnt         <= RST_LOAD;
                        pll_reset   <= 1'b1;
                        retry_count <= sat_inc(retry_count);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                STABLE, RELEASE, RUN: begin
                    if (!lock_s) begin
                        state        <= PLL_RST;
                        cnt          <= RST_LOAD;
                        pll_reset    <= 1'b1;
                        domain_reset <= '1;
                        ready        <= 1'b0;
                        lock_lost    <= 1'b1;
                        retry_count  <= sat_inc(retry_count);
                    end else if (state == STABLE) begin
                        if (cnt_done) begin
                            state <= RELEASE;
                            cnt   <= REL_LOAD;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end else if (state == RELEASE) begin
                        domain_reset <= rel_hold;
                        if (cnt_done) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state        <= PLL_RST;
                    cnt          <= RST_LOAD;
                    pll_reset    <= 1'b1;
                    domain_reset <= '1;
                    ready        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       clk_in1;
    logic       reset;
    logic       locked;
    logic       pll_reset;
    logic [2:0] domain_reset;
    logic       ready;
    logic [7:0] retry_count;
    logic       lock_lost;

    int total;
    int bad;
    int cyc;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (50),
        .STABLE_CYCLES  (10),
        .NUM_DOMAINS    (3),
        .STAGGER_CYCLES (2)
    ) dut (
        .clk_in1      (clk_in1),
        .reset        (reset),
        .locked       (locked),
        .pll_reset    (pll_reset),
        .domain_reset (domain_reset),
        .ready        (ready),
        .retry_count  (retry_count),
        .lock_lost    (lock_lost)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in1);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    // Edge k after this returns is the k-th edge with reset low.
    task automatic do_reset(input logic lk);
        reset  = 1'b1;
        locked = lk;
        tick();
        chk("rst_pll", 32'(pll_reset), 32'd1);
        chk("rst_dom", 32'(domain_reset), 32'h7);
        chk("rst_rdy", 32'(ready), 32'd0);
        chk("rst_ll", 32'(lock_lost), 32'd0);
        chk("rst_cnt", 32'(retry_count), 32'd0);
        tick();
        chk("rst_hold_pll", 32'(pll_reset), 32'd1);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        reset  = 1'b1;
        locked = 1'b0;

        // Normal bring-up, lock arriving at cycle 10, then lock loss in RUN.
        do_reset(1'b0);
        tick_to(3);  chk("bring_pll3", 32'(pll_reset), 32'd1);
        tick_to(4);  chk("bring_pll4", 32'(pll_reset), 32'd0);
        tick_to(10); locked = 1'b1;
        tick_to(23); chk("bring_dom23", 32'(domain_reset), 32'h7);
        tick_to(24); chk("bring_dom24", 32'(domain_reset), 32'h7);
        tick_to(25); chk("bring_dom25", 32'(domain_reset), 32'h6);
        tick_to(26); chk("bring_dom26", 32'(domain_reset), 32'h6);
        tick_to(27); chk("bring_dom27", 32'(domain_reset), 32'h4);
        tick_to(29); chk("bring_dom29", 32'(domain_reset), 32'h0);
                     chk("bring_rdy29", 32'(ready), 32'd0);
        tick_to(30); chk("bring_rdy30", 32'(ready), 32'd0);
        tick_to(31); chk("bring_rdy31", 32'(ready), 32'd1);
                     chk("bring_cnt", 32'(retry_count), 32'd0);
        locked = 1'b0;
        tick_to(33); chk("loss_dom33", 32'(domain_reset), 32'h0);
                     chk("loss_rdy33", 32'(ready), 32'd1);
                     chk("loss_ll33", 32'(lock_lost), 32'd0);
        tick_to(34); chk("loss_dom34", 32'(domain_reset), 32'h7);
                     chk("loss_rdy34", 32'(ready), 32'd0);
                     chk("loss_ll34", 32'(lock_lost), 32'd1);
                     chk("loss_cnt34", 32'(retry_count), 32'd1);
                     chk("loss_pll34", 32'(pll_reset), 32'd1);
        locked = 1'b1;
        tick_to(35); chk("loss_ll35", 32'(lock_lost), 32'd0);
        tick_to(56); chk("rerun_rdy56", 32'(ready), 32'd0);
        tick_to(57); chk("rerun_rdy57", 32'(ready), 32'd1);
                     chk("rerun_dom57", 32'(domain_reset), 32'h0);
                     chk("rerun_cnt57", 32'(retry_count), 32'd1);

        // Lock timeouts with locked held low, running on into saturation.
        do_reset(1'b0);
        tick_to(53);  chk("to_pll53", 32'(pll_reset), 32'd0);
                      chk("to_cnt53", 32'(retry_count), 32'd0);
        tick_to(54);  chk("to_pll54", 32'(pll_reset), 32'd1);
                      chk("to_cnt54", 32'(retry_count), 32'd1);
        tick_to(57);  chk("to_pll57", 32'(pll_reset), 32'd1);
        tick_to(58);  chk("to_pll58", 32'(pll_reset), 32'd0);
        tick_to(108); chk("to_cnt108", 32'(retry_count), 32'd2);
        tick_to(162); chk("to_cnt162", 32'(retry_count), 32'd3);
                      chk("to_rdy162", 32'(ready), 32'd0);
        tick_to(54 * 255 - 1); chk("sat_254", 32'(retry_count), 32'd254);
        tick_to(54 * 255);     chk("sat_255", 32'(retry_count), 32'd255);
        tick_to(54 * 300);     chk("sat_300", 32'(retry_count), 32'd255);
                               chk("sat_rdy", 32'(ready), 32'd0);

        // Lock drop in STABLE at count 5, then reset mid-RELEASE.
        do_reset(1'b1);
        tick_to(10); locked = 1'b0;
        tick_to(12); chk("stb_dom12", 32'(domain_reset), 32'h7);
                     chk("stb_ll12", 32'(lock_lost), 32'd0);
                     chk("stb_pll12", 32'(pll_reset), 32'd0);
        tick_to(13); chk("stb_ll13", 32'(lock_lost), 32'd1);
                     chk("stb_cnt13", 32'(retry_count), 32'd1);
                     chk("stb_pll13", 32'(pll_reset), 32'd1);
                     chk("stb_dom13", 32'(domain_reset), 32'h7);
        locked = 1'b1;
        tick_to(29); chk("stb_dom29", 32'(domain_reset), 32'h7);
        tick_to(30); chk("stb_dom30", 32'(domain_reset), 32'h6);
        reset = 1'b1;
        tick();
        chk("mid_dom", 32'(domain_reset), 32'h7);
        chk("mid_pll", 32'(pll_reset), 32'd1);
        chk("mid_cnt", 32'(retry_count), 32'd0);
        chk("mid_rdy", 32'(ready), 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
